// File: rtl/bcd_scan_counter_if.sv
// Control and display bundle for the BCD scan counter.
// The master drives count control; the slave returns count and scan lines.
interface bcd_scan_counter_if;
   logic        En;
   logic        Up;
   logic        Load;
   logic [15:0] LoadVal;
   logic [15:0] Count;
   logic        Carry;
   logic [3:0]  Bcd;
   logic [3:0]  An;

   modport master (
      output En, Up, Load, LoadVal,
      input  Count, Carry, Bcd, An
   );

   modport slave (
      input  En, Up, Load, LoadVal,
      output Count, Carry, Bcd, An
   );
endinterface

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with a multiplexed digit scanner.
// Define BCD_SCAN_BLANK_EN to blank leading zeros on the digit selects.
module bcd_scan_counter #(
   parameter int TICK_DIV = 50_000_000,
   parameter int SCAN_DIV = 100_000
) (
   input logic              Clk,
   input logic              Rst,
   bcd_scan_counter_if.slave bus
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [15:0]   count_q;
   logic          carry_q;
   logic [15:0]   load_clean;
   logic [15:0]   step_val;
   logic          wrap;
   logic [SW-1:0] scan_cnt;
   logic          scan_last;
   logic [1:0]    idx;
   logic [1:0]    idx_n;
   logic [3:0]    an_n;
   logic [3:0]    an_q;
   logic [3:0]    bcd_q;

   assign tick = bus.En && (tick_cnt == TICK_LAST);

   always_ff @(posedge Clk) begin
      if (Rst || bus.Load)
         tick_cnt <= '0;
      else if (bus.En)
         tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
   end

   always_comb begin
      load_clean = '0;
      for (int i = 0; i < 4; i++)
         load_clean[4*i +: 4] = (bus.LoadVal[4*i +: 4] > 4'd9) ?
                                4'd0 : bus.LoadVal[4*i +: 4];
   end

   // Ripple the carry/borrow digit by digit; it survives only past 9s or 0s.
   always_comb begin
      logic [3:0] d;
      step_val = count_q;
      wrap     = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d = count_q[4*i +: 4];
         if (wrap) begin
            if (bus.Up) begin
               if (d == 4'd9) begin
                  step_val[4*i +: 4] = 4'd0;
               end else begin
                  step_val[4*i +: 4] = d + 4'd1;
                  wrap = 1'b0;
               end
            end else begin
               if (d == 4'd0) begin
                  step_val[4*i +: 4] = 4'd9;
               end else begin
                  step_val[4*i +: 4] = d - 4'd1;
                  wrap = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         count_q <= '0;
         carry_q <= 1'b0;
      end else begin
         carry_q <= 1'b0;
         if (bus.Load) begin
            count_q <= load_clean;
         end else if (tick) begin
            count_q <= step_val;
            carry_q <= wrap;
         end
      end
   end

   assign scan_last = (scan_cnt == SCAN_LAST);
   assign idx_n     = scan_last ? idx + 2'd1 : idx;

`ifdef BCD_SCAN_BLANK_EN
   logic [3:1] lead;
   always_comb begin
      lead[3] = (count_q[15:12] == 4'd0);
      lead[2] = lead[3] && (count_q[11:8] == 4'd0);
      lead[1] = lead[2] && (count_q[7:4] == 4'd0);
      an_n    = ~(4'b0001 << idx_n);
      if (idx_n != 2'd0 && lead[idx_n])
         an_n = 4'b1111;
   end
`else
   always_comb begin
      an_n = ~(4'b0001 << idx_n);
   end
`endif

   // Select and digit register together so An and Bcd always agree.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         scan_cnt <= '0;
         idx      <= 2'd0;
         an_q     <= 4'b1110;
         bcd_q    <= 4'd0;
      end else begin
         scan_cnt <= scan_last ? '0 : scan_cnt + SW'(1);
         idx      <= idx_n;
         an_q     <= an_n;
         bcd_q    <= count_q[{idx_n, 2'b00} +: 4];
      end
   end

   assign bus.Count = count_q;
   assign bus.Carry = carry_q;
   assign bus.An    = an_q;
   assign bus.Bcd   = bcd_q;
endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench for bcd_scan_counter with TICK_DIV=4, SCAN_DIV=2.
// A decimal reference model pushes expectations; they are popped after each edge.
module tb_bcd_scan_counter;
   localparam int TD = 4;
   localparam int SD = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bcd_scan_counter_if bif();

   bcd_scan_counter #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
      .Clk(clk),
      .Rst(rst),
      .bus(bif.slave)
   );

   typedef struct {
      logic [15:0] count;
      logic        carry;
      logic [3:0]  an;
      logic [3:0]  bcd;
   } exp_t;

   exp_t sbq[$];
   int checks = 0;
   int fails  = 0;
   int m_cnt  = 0;
   int m_tick = 0;
   int m_sdiv = 0;
   int m_sidx = 0;

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      return {4'((v / 1000) % 10), 4'((v / 100) % 10),
              4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic int clean(input logic [15:0] v);
      int r = 0;
      int pw = 1;
      logic [3:0] n;
      for (int i = 0; i < 4; i++) begin
         n = v[4*i +: 4];
         if (n <= 4'd9) r += int'(n) * pw;
         pw *= 10;
      end
      return r;
   endfunction

   task automatic step();
      exp_t e;
      int old, pw;
      bit tick_ev;
      old = m_cnt;
      e.carry = 1'b0;
      if (rst) begin
         m_cnt = 0; m_tick = 0; m_sdiv = 0; m_sidx = 0;
         e.an = 4'b1110;
         e.bcd = 4'd0;
      end else begin
         tick_ev = bif.En && (m_tick == TD - 1);
         if (bif.Load) begin
            m_cnt = clean(bif.LoadVal);
            m_tick = 0;
         end else begin
            if (bif.En) m_tick = tick_ev ? 0 : m_tick + 1;
            if (tick_ev) begin
               if (bif.Up) begin
                  e.carry = (old == 9999);
                  m_cnt = (old + 1) % 10000;
               end else begin
                  e.carry = (old == 0);
                  m_cnt = (old + 9999) % 10000;
               end
            end
         end
         if (m_sdiv == SD - 1) begin
            m_sdiv = 0;
            m_sidx = (m_sidx + 1) % 4;
         end else begin
            m_sdiv++;
         end
         pw = 1;
         for (int k = 0; k < m_sidx; k++) pw *= 10;
         e.bcd = 4'((old / pw) % 10);
         e.an = ~(4'b0001 << m_sidx);
`ifdef BCD_SCAN_BLANK_EN
         if (m_sidx > 0 && old < pw) e.an = 4'b1111;
`endif
      end
      e.count = to_bcd(m_cnt);
      sbq.push_back(e);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      check("count", bif.Count, e.count);
      check("carry", {15'b0, bif.Carry}, {15'b0, e.carry});
      check("an", {12'b0, bif.An}, {12'b0, e.an});
      check("bcd", {12'b0, bif.Bcd}, {12'b0, e.bcd});
   endtask

   task automatic load(input logic [15:0] v, input logic en);
      bif.Load = 1'b1;
      bif.LoadVal = v;
      bif.En = en;
      step();
      bif.Load = 1'b0;
   endtask

   initial begin
      int ncar;
      bit found;
      int blank_bad;
      rst = 1'b1;
      bif.En = 1'b0;
      bif.Up = 1'b1;
      bif.Load = 1'b0;
      bif.LoadVal = 16'h0000;
      step();
      step();
      check("rst_count", bif.Count, 16'h0000);
      check("rst_an", {12'b0, bif.An}, 16'h000e);

      rst = 1'b0;
      bif.En = 1'b1;
      bif.Up = 1'b1;
      for (int i = 0; i < 44; i++) begin
         step();
         if (i == 2) check("s1_pre", bif.Count, 16'h0000);
         if (i == 3) check("s1_first", bif.Count, 16'h0001);
      end
      check("s1_end", bif.Count, 16'h0011);

      load(16'h9998, 1'b0);
      bif.En = 1'b1;
      ncar = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         ncar += int'(bif.Carry);
         if (i == 3) check("s2_9999", bif.Count, 16'h9999);
         if (i == 7) check("s2_wrap", bif.Count, 16'h0000);
         if (i == 7) check("s2_carry", {15'b0, bif.Carry}, 16'h0001);
      end
      check("s2_ncarry", 16'(ncar), 16'h0001);

      load(16'h0000, 1'b0);
      bif.Up = 1'b0;
      bif.En = 1'b1;
      repeat (4) step();
      check("s3_9999", bif.Count, 16'h9999);
      check("s3_carry", {15'b0, bif.Carry}, 16'h0001);
      repeat (4) step();
      check("s3_9998", bif.Count, 16'h9998);
      check("s3_nocarry", {15'b0, bif.Carry}, 16'h0000);

      bif.Up = 1'b1;
      load(16'h0000, 1'b0);
      bif.En = 1'b1;
      repeat (3) step();
      load(16'h1A2F, 1'b1);
      check("s4_load", bif.Count, 16'h1020);
      check("s4_carry", {15'b0, bif.Carry}, 16'h0000);
      repeat (3) step();
      check("s4_hold", bif.Count, 16'h1020);
      step();
      check("s4_tick", bif.Count, 16'h1021);

      bif.Load = 1'b1;
      bif.LoadVal = 16'h0123;
      bif.En = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (bif.An == 4'b1011 && bif.Count == 16'h0123) found = 1'b1;
      end
      check("s5_find", {15'b0, found}, 16'h0001);
      bif.Load = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("s5_count", bif.Count, 16'h0000);
      check("s5_an", {12'b0, bif.An}, 16'h000e);
      check("s5_bcd", {12'b0, bif.Bcd}, 16'h0000);
      check("s5_carry", {15'b0, bif.Carry}, 16'h0000);

      load(16'h0042, 1'b0);
      bif.En = 1'b0;
      repeat (8) step();
      load(16'h0000, 1'b0);
      blank_bad = 0;
      for (int i = 0; i < 8; i++) begin
         step();
`ifdef BCD_SCAN_BLANK_EN
         if (bif.An != 4'b1110 && bif.An != 4'b1111) blank_bad++;
`else
         if (bif.An == 4'b1111) blank_bad++;
`endif
      end
      check("s6_blank", 16'(blank_bad), 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/bcd_scan_counter.md
# bcd_scan_counter

Four-digit decimal (BCD) up/down counter with a built-in time-multiplexed display scanner. It is the stage directly upstream of the BCD-to-seven-segment decoder. It presents one digit at a time on `Bcd`, drives the matching active-low digit-select line on `An`, and exposes the full count for other logic. Counting is paced by an internal prescaler, so a slow visible count and a fast scan both run from the single system clock.

## Interface

Parameters:

- `TICK_DIV`, default 50_000_000: clock cycles per count step while `En`=1; legal range ≥1.
- `SCAN_DIV`, default 100_000: clock cycles each digit is shown; legal range ≥1.

Ports:

- `Clk` input, 1: system clock. All state changes on its rising edge.
- `Rst` input, 1: reset. Synchronous and active-high.
- `En` input, 1: count enable. Gates the tick prescaler.
- `Up` input, 1: direction. 1 = count up, 0 = count down. Sampled on the tick cycle.
- `Load` input, 1: synchronous load of `LoadVal`.
- `LoadVal` input, 16: load value, as four BCD digits; [3:0] is the units digit.
- `Count` output, 16: current count, as four BCD digits; [3:0] is the units digit.
- `Carry` output, 1: one-cycle pulse on wrap-around.
- `Bcd` output, 4: digit currently scanned. This port feeds the segment decoder.
- `An` output, 4: digit select, active-low one-hot. `An[0]` selects the units digit.

## Operation

Reset (`Rst`=1 at a rising edge). Reset overrides every other input, at any time:

- `Count`=16'h0000, `Carry`=0.
- Tick and scan prescalers are cleared to 0.
- Scan index is 0, `An`=4'b1110, `Bcd`=4'h0.

Tick prescaler:

- Counts 0..TICK_DIV-1, advancing only on cycles where `En`=1; it holds its value while `En`=0.
- A tick occurs on any cycle where `En`=1 and the prescaler equals TICK_DIV-1. The prescaler returns to 0 on that cycle.
- With TICK_DIV=1, every cycle with `En`=1 is a tick.

Count update. Priority is `Load` > tick:

- `Load`=1: `Count` takes `LoadVal` on the next edge and the tick prescaler is cleared.
  - Any loaded digit greater than 9 is replaced by 0.
  - `Carry` is not asserted.
  - A tick coinciding with `Load` is discarded.
- Tick with `Up`=1: decimal increment with per-digit carry. 9999 → 0000 and `Carry`=1 for one cycle.
- Tick with `Up`=0: decimal decrement with per-digit borrow. 0000 → 9999 and `Carry`=1 for one cycle.
- `Carry` is high only in the cycle where `Count` first shows the wrapped value. It is 0 at all other times.
- Digits never hold values 10–15.

Scanner:

- Runs independently of `En`, `Load` and `Up`.
- The scan prescaler counts 0..SCAN_DIV-1. At terminal count the scan index advances 0→1→2→3→0.
- `An` is the active-low one-hot of the index.
- `Bcd` is the `Count` digit selected by the index.
- `Bcd` and `An` are both registered and always change on the same edge.
- `Bcd` is re-sampled every cycle, so a count change on a displayed digit appears on `Bcd` one cycle after it appears on `Count`.

## Timing

- `Count` and `Carry` update on the edge that ends the tick or load cycle. Latency from the tick or `Load` cycle to the output is one cycle.
- `Bcd` lags `Count` by one cycle.
- `An` changes every SCAN_DIV cycles.
- Scan period is 4·SCAN_DIV cycles.
- After reset is released, the first index advance is SCAN_DIV cycles later.
- After reset is released, the first tick occurs on the TICK_DIV-th cycle with `En`=1.
- There are no combinational input-to-output paths; every output is a register.

## Configuration

Macro `BCD_SCAN_BLANK_EN` controls leading-zero blanking.

- Defined:
  - While the scanned digit is a leading zero of `Count`, `An` is driven to 4'b1111 for that slot. `Bcd` still carries 0.
  - Leading zeros are the zero digits above the most significant non-zero digit.
  - The units digit is never blanked, so 0000 displays as a single 0.
  - Slot timing is unchanged.
- Undefined: all four digits are always selected in turn, including leading zeros.

## Test plan

All scenarios use TICK_DIV=4 and SCAN_DIV=2.

1. Reset release, then `En`=1, `Up`=1 for 44 cycles → `Count` steps 0000→0001 on the 4th enabled cycle and reaches 0011. `An` cycles 1110,1101,1011,0111, changing every 2 cycles.
2. `Load` with `LoadVal`=16'h9998, then `En`=1, `Up`=1 for 8 cycles → `Count` goes 9999, then 0000 with `Carry`=1 for exactly that one cycle.
3. `Load` with `LoadVal`=16'h0000, then `Up`=0 for one tick → `Count`=9999, `Carry`=1 for one cycle. A further tick gives 9998, `Carry`=0.
4. `Load` with `LoadVal`=16'h1A2F in the same cycle as a tick → `Count`=16'h1020, no increment, `Carry`=0, and the next tick comes 4 enabled cycles later.
5. Assert `Rst` mid-count at `Count`=0123 while `En`=1, in a cycle where `An`=1011 → next cycle `Count`=0000, `An`=1110, `Bcd`=0, `Carry`=0.
6. With `BCD_SCAN_BLANK_EN` defined, `Count`=0042 → `An`=1111 in slots 2 and 3. With `Count`=0000 → only slot 0 is selected, `Bcd`=0.
